// File: rtl/unidad_control_alu_if.sv
// Bundle of fetch port, register-file port, ALU operand/result and status lines
// between the fetch/decode/execute sequencer (master) and its environment (slave).
interface unidad_control_alu_if;
  logic        mem_req;
  logic [31:0] mem_dir;
  logic        mem_ack;
  logic [31:0] mem_dato;
  logic [4:0]  rf_dir_a;
  logic [4:0]  rf_dir_b;
  logic [31:0] rf_dato_a;
  logic [31:0] rf_dato_b;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  operador;
  logic [31:0] resultado;
  logic        rf_we;
  logic [4:0]  rf_dir_w;
  logic [31:0] rf_dato_w;
  logic [31:0] pc;
  logic        halt;
  logic        ilegal;

  modport master (
    output mem_req, mem_dir, rf_dir_a, rf_dir_b, a, b, operador,
           rf_we, rf_dir_w, rf_dato_w, pc, halt, ilegal,
    input  mem_ack, mem_dato, rf_dato_a, rf_dato_b, resultado
  );

  modport slave (
    input  mem_req, mem_dir, rf_dir_a, rf_dir_b, a, b, operador,
           rf_we, rf_dir_w, rf_dato_w, pc, halt, ilegal,
    output mem_ack, mem_dato, rf_dato_a, rf_dato_b, resultado
  );
endinterface

// File: rtl/unidad_control_alu.sv
// Multi-cycle fetch/decode/execute/writeback sequencer feeding an external
// combinational ALU; every output is a register or a decode of the state register.
module unidad_control_alu #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
  parameter logic [31:0] PASO_PC    = 32'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  unidad_control_alu_if.master bus
);

  typedef enum logic [2:0] {
    INICIO, FETCH, DECODE, EXECUTE, WRITEBACK, DETENIDO
  } estado_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [12:0] resto;
  } instr_t;

  estado_t     r_estado;
  logic [31:0] r_pc;
  logic [3:0]  r_ir_op;
  logic [4:0]  r_ir_rd;
  logic [4:0]  r_dir_a;
  logic [4:0]  r_dir_b;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [4:0]  r_dir_w;
  logic [31:0] r_dato_w;
  logic        r_we_pend;
  logic        r_ilegal;

  instr_t w_instr;
  logic   w_op_alu;
  logic   w_op_ilegal;

  assign w_instr     = instr_t'(bus.mem_dato);
  assign w_op_alu    = (r_ir_op <= 4'd6);
  assign w_op_ilegal = (r_ir_op >= 4'd8) && (r_ir_op <= 4'd14);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado  <= INICIO;
      r_pc      <= PC_INICIAL;
      r_ir_op   <= '0;
      r_ir_rd   <= '0;
      r_dir_a   <= '0;
      r_dir_b   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_dir_w   <= '0;
      r_dato_w  <= '0;
      r_we_pend <= 1'b0;
      r_ilegal  <= 1'b0;
    end else begin
      case (r_estado)
        INICIO: r_estado <= FETCH;
        FETCH: begin
          // Read addresses are taken straight from the incoming word so the
          // register file has a full cycle to settle during DECODE.
          if (bus.mem_ack) begin
            r_ir_op  <= w_instr.opcode;
            r_ir_rd  <= w_instr.rd;
            r_dir_a  <= w_instr.rs;
            r_dir_b  <= w_instr.rt;
            r_estado <= DECODE;
          end
        end
        DECODE: begin
          r_a       <= bus.rf_dato_a;
          r_b       <= bus.rf_dato_b;
          r_op      <= r_ir_op;
          r_dir_w   <= r_ir_rd;
          r_we_pend <= w_op_alu && (r_ir_rd != 5'd0);
          if (w_op_ilegal)
            r_ilegal <= 1'b1;
          if (r_ir_op == 4'd15)
            r_estado <= DETENIDO;
          else if (w_op_alu)
            r_estado <= EXECUTE;
          else
            r_estado <= WRITEBACK;
        end
        EXECUTE: begin
          r_dato_w <= bus.resultado;
          r_estado <= WRITEBACK;
        end
        WRITEBACK: begin
          r_pc      <= r_pc + PASO_PC;
          r_we_pend <= 1'b0;
          r_estado  <= FETCH;
        end
        DETENIDO: r_estado <= DETENIDO;
        default:  r_estado <= INICIO;
      endcase
    end
  end

  assign bus.mem_req   = (r_estado == FETCH);
  assign bus.mem_dir   = r_pc;
  assign bus.pc        = r_pc;
  assign bus.rf_dir_a  = r_dir_a;
  assign bus.rf_dir_b  = r_dir_b;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.operador  = r_op;
  assign bus.rf_we     = (r_estado == WRITEBACK) && r_we_pend;
  assign bus.rf_dir_w  = r_dir_w;
  assign bus.rf_dato_w = r_dato_w;
  assign bus.halt      = (r_estado == DETENIDO);
  assign bus.ilegal    = r_ilegal;

endmodule

// File: doc/unidad_control_alu.md
# unidad_control_alu

Multi-cycle fetch/decode/execute sequencer for the fetch-cycle datapath. It fetches 32-bit instructions over a request/acknowledge memory port and reads operands from the register file. It drives the operands and 4-bit operation code into the combinational ALU, captures the ALU result, and writes it back to the register file. It is the control-side counterpart of the ALU: it produces `a`, `b`, and `operador`, and consumes `resultado`.

## Interface
- `PC_INICIAL`, 32'h0000_0000, PC value loaded on reset.
- `PASO_PC`, 4, PC increment per retired instruction.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  instruction fetch request.
- `mem_dir`  out  32  fetch address; equals PC.
- `mem_ack`  in  1  fetch data valid.
- `mem_dato`  in  32  instruction word.
- `rf_dir_a`, `rf_dir_b`  out  5  register file read addresses (rs, rt).
- `rf_dato_a`, `rf_dato_b`  in  32  register file read data; combinational read.
- `a`, `b`  out  32  ALU operands.
- `operador`  out  4  ALU operation code.
- `resultado`  in  32  ALU result.
- `rf_we`  out  1  register write enable.
- `rf_dir_w`  out  5  write address (rd).
- `rf_dato_w`  out  32  write data.
- `pc`  out  32  current PC.
- `halt`  out  1  sticky; processor stopped.
- `ilegal`  out  1  sticky; an illegal opcode was seen.

## Operation
- Instruction format:
  - [31:28] opcode
  - [27:23] rd
  - [22:18] rs
  - [17:13] rt
  - [12:0] ignored
- Opcodes 0–6 are ALU operations passed unchanged on `operador`:
  - 0 = add, 1 = and, 2 = equal (result 1/0), 3 = unsigned greater-than (result 1/0)
  - 4 = a<<1, 5 = a>>1 (both ignore `b`), 6 = sub
- Opcode 7 is a NOP. Opcode 15 is HALT. Opcodes 8–14 are illegal: set `ilegal` and retire as a NOP.
- FSM states: INICIO, FETCH, DECODE, EXECUTE, WRITEBACK, DETENIDO.
  - INICIO: entered on reset. Goes to FETCH on the next edge.
  - FETCH: `mem_req`=1, `mem_dir`=PC. On an edge with `mem_ack`=1, latch `mem_dato` into IR and go to DECODE. Otherwise stay.
  - DECODE: `rf_dir_a`=IR.rs, `rf_dir_b`=IR.rt. Register `rf_dato_a`/`rf_dato_b` into `a`/`b` and IR.opcode into `operador`.
    - Opcode 15: go to DETENIDO.
    - Opcodes 7–14: skip to WRITEBACK with the write suppressed.
    - Otherwise: go to EXECUTE.
  - EXECUTE: `a`, `b`, `operador` held stable. Capture `resultado` into `rf_dato_w`. Go to WRITEBACK.
  - WRITEBACK: `rf_we`=1 for exactly this cycle, only if the opcode is 0–6 and rd≠0. PC ← PC+PASO_PC, modulo 2^32. Go to FETCH.
  - DETENIDO: `halt`=1. No requests and no writes. Stays here until reset.
- Writes to r0 are always suppressed.
- PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `mem_ack` is ignored in every state except FETCH.
- `ilegal` is sticky until reset. It is set on the DECODE edge.

## Timing
- Every output is registered or a pure decode of the state register. No output depends combinationally on `mem_ack` or `resultado`.
- Reset values:
  - `mem_req`=0, `rf_we`=0, `halt`=0, `ilegal`=0
  - `pc`=`mem_dir`=PC_INICIAL
  - `a`=`b`=`rf_dato_w`=0, `operador`=0
  - `rf_dir_a`=`rf_dir_b`=`rf_dir_w`=0
  - state INICIO
- The first `mem_req` is asserted one cycle after reset deasserts.
- With `mem_ack` returned in the first FETCH cycle, an ALU instruction takes 4 cycles from FETCH entry to FETCH re-entry. A NOP or illegal instruction takes 3.
- Each additional memory wait cycle adds one cycle.
- `mem_dir` is stable for the whole time `mem_req`=1.
- `rf_dir_w` and `rf_dato_w` are stable throughout the cycle in which `rf_we`=1.
- Reset asserted in any state, including mid-fetch, immediately forces all reset values. The in-flight instruction is discarded and the PC does not advance.

## Test plan
- Reset, then `mem_ack`=1 every cycle with instruction add r3,r1,r2, where r1=5 and r2=7. Expect: `mem_req` high at cycle 1; `operador`=0; write of 12 to r3; `pc`=4 after 4 cycles.
- Instruction sub r4,r1,r2 with r1=3 and r2=5. Expect a write of 32'hFFFF_FFFE to r4. Opcode 2 with equal operands writes 1. Opcode 3 with a=2, b=9 writes 0.
- Delay `mem_ack` by 3 cycles. Expect `mem_req` and `mem_dir` held constant for 4 cycles, and the instruction to complete 3 cycles later than in the no-wait case.
- Add with rd=0, then a NOP, then opcode 9. Expect `rf_we` never asserted, `ilegal`=1 after the third instruction's DECODE, and `pc` advanced by 12.
- PC_INICIAL=32'hFFFF_FFFC with one NOP. Expect `pc` to wrap to 0. Then a HALT instruction: expect `halt`=1, `mem_req`=0 indefinitely, and `pc` frozen.
- Assert reset during FETCH while `mem_req`=1. Expect `mem_req` to drop in the same cycle and `pc`=PC_INICIAL. After release, fetch restarts from PC_INICIAL.
